bidir_index_dual_port_ram: RTL

//  Simple dual-port RAM (1 write port, 1 read port) addressed by signed, Python-style indices:
//  idx >= 0 counts from the start, idx < 0 counts back from the end (-1 = last element).

---
 rtl/bidir_ram_pkg.sv | 23 ++
 rtl/bidir_index_norm.sv | 23 ++
 rtl/bidir_index_dual_port_ram.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bidir_ram_pkg.sv
// Shared types and helpers for list-object storage blocks that use
// Python-style signed indices (negative values count back from the end).
package bidir_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // True when idx addresses an existing element of a list of length len.
    function automatic logic in_range(input int idx, input int len);
        return (idx >= -len) && (idx <= len - 1);
    endfunction

    function automatic int phys_addr(input int idx, input int len);
        return (idx < 0) ? (len + idx) : idx;
    endfunction

    function automatic int min1_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bidir_index_norm.sv
// Converts a signed list index into a physical RAM address and flags
// indices that fall outside the list.
module bidir_index_norm
    import bidir_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int RAM_LENGTH = 16,
    parameter int PHYS_WIDTH = min1_clog2(RAM_LENGTH)
) (
    input  logic [ADDR_WIDTH-1:0] idx_i,
    output logic [PHYS_WIDTH-1:0] phys_o,
    output logic                  oob_o
);

    int idx_s;

    always_comb begin
        idx_s  = int'($signed(idx_i));
        phys_o = PHYS_WIDTH'(phys_addr(idx_s, RAM_LENGTH));
        oob_o  = !in_range(idx_s, RAM_LENGTH);
    end

endmodule

// File: rtl/bidir_index_dual_port_ram.sv
// One-write/one-read RAM addressed by signed list indices, with bounds
// checking, a registered (optionally double-registered) read and zero-fill after reset.
module bidir_index_dual_port_ram
    import bidir_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 5,
    parameter int RAM_LENGTH     = 16,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_err_o,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_err_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] len_o
);

    localparam int              PTR_W       = min1_clog2(RAM_LENGTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(RAM_LENGTH - 1);
    localparam state_e          RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic            RESET_BUSY  = (CLEAR_ON_RESET != 0);

    logic [DATA_WIDTH-1:0] mem_q [RAM_LENGTH];

    state_e                state_q;
    logic [PTR_W-1:0]      clear_ptr_q;
    logic                  busy_q;

    logic [PTR_W-1:0]      wr_phys;
    logic [PTR_W-1:0]      rd_phys;
    logic                  wr_oob;
    logic                  rd_oob;
    logic                  idle;
    logic                  wr_fire;
    logic                  rd_fire;

    logic                  wr_err_q;
    logic                  s1_valid_q;
    logic                  s1_err_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    bidir_index_norm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_LENGTH (RAM_LENGTH),
        .PHYS_WIDTH (PTR_W)
    ) u_wr_norm (
        .idx_i  (wr_idx_i),
        .phys_o (wr_phys),
        .oob_o  (wr_oob)
    );

    bidir_index_norm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_LENGTH (RAM_LENGTH),
        .PHYS_WIDTH (PTR_W)
    ) u_rd_norm (
        .idx_i  (rd_idx_i),
        .phys_o (rd_phys),
        .oob_o  (rd_oob)
    );

    assign idle    = (state_q == ST_IDLE);
    assign wr_fire = idle && wr_en_i && !wr_oob;
    assign rd_fire = idle && rd_en_i;

    // Clear sweep: one entry per cycle, then normal operation until the next reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RESET_STATE;
            clear_ptr_q <= '0;
            busy_q      <= RESET_BUSY;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clear_ptr_q == LAST_PTR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clear_ptr_q <= clear_ptr_q + PTR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clear_ptr_q] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_phys] <= wr_data_i;
        end
    end

    // The read samples the array before this edge's write lands, so a
    // same-address read/write returns the old contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_data_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= rd_fire;
            s1_err_q   <= rd_fire && rd_oob;
            if (rd_fire) begin
                s1_data_q <= rd_oob ? '0 : mem_q[rd_phys];
            end
            wr_err_q   <= wr_en_i && (!idle || wr_oob);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  s2_valid_q;
            logic                  s2_err_q;
            logic [DATA_WIDTH-1:0] s2_data_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s2_valid_q <= 1'b0;
                    s2_err_q   <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    s2_err_q   <= s1_err_q;
                    s2_data_q  <= s1_data_q;
                end
            end

            assign rd_valid_o = s2_valid_q;
            assign rd_err_o   = s2_err_q;
            assign rd_data_o  = s2_data_q;
        end else begin : g_no_out_reg
            assign rd_valid_o = s1_valid_q;
            assign rd_err_o   = s1_err_q;
            assign rd_data_o  = s1_data_q;
        end
    endgenerate

    assign wr_err_o = wr_err_q;
    assign busy_o   = busy_q;
    assign len_o    = ADDR_WIDTH'(RAM_LENGTH);

endmodule
